decode_stage: RTL and testbench

//  - RV32 decode stage: IF/DE and DE/EXE pipeline registers, 32x32 register file, immediate generation.
//  - Sits between fetch and execute. Presents instr_de to the hazard/forwarding unit.
//  - Consumes that unit's stall, hazard_a/b and data_a_mgr/b_mgr to pick the execute operands.

---
 rtl/rv32_pkg.sv | 44 ++++
 rtl/regfile_2r1w.sv | 52 +++++
 rtl/decode_stage.sv | 135 +++++++++++++
 tb/tb_decode_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// RV32 decode-stage shared definitions.
// Contents:
//   - XLEN and the bubble encodings (NOP_INSTR, BUBBLE_PC).
//   - Major-opcode localparams.
//   - The immediate-format enum and the opcode -> format map.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] BUBBLE_PC = 32'h0000_0000;  // pc 0 marks "no instruction"

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  // R-type and unknown opcodes carry no immediate.
  function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32 x 32 register file: two asynchronous read ports and one write port.
// Behaviour:
//   - x0 always reads 0, and a write to x0 is dropped.
//   - A read of the register being written in the same cycle returns wb_data.
//   - Every entry clears on rst (asynchronous, active-high).
// Ports:
//   clk, rst            clock / async active-high reset
//   rs1_addr, rs2_addr  read addresses
//   rs1_data, rs2_data  read data (combinational)
//   wb_en, wb_rd        write enable / destination
//   wb_data             write data
module regfile_2r1w
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] mem [32];
  logic            wr_live;

  assign wr_live = wb_en && (wb_rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[wb_rd] <= wb_data;
    end
  end

  // The x0 check comes first, so it also covers the bypass (wr_live already excludes x0).
  always_comb begin
    rs1_data = mem[rs1_addr];
    if (rs1_addr == 5'd0)                  rs1_data = '0;
    else if (wr_live && wb_rd == rs1_addr) rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = mem[rs2_addr];
    if (rs2_addr == 5'd0)                  rs2_data = '0;
    else if (wr_live && wb_rd == rs2_addr) rs2_data = wb_data;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage.
// Contents:
//   - IF/DE pipeline register.
//   - DE/EXE pipeline register.
//   - Register file.
//   - Immediate generation.
// Handshake: valid_if qualifies instr_if/pc_if. An invalid fetch, a flush or a
// stall-induced bubble is carried down the pipe as NOP_INSTR with pc BUBBLE_PC
// and a cleared valid bit, so nothing downstream needs a separate kill line.
// Ports:
//   clk, rst                          clock / async active-high reset
//   instr_if, pc_if, valid_if         fetched instruction
//   stall                             hold DE, inject a bubble into EXE
//   flush                             squash DE and EXE (wins over stall)
//   hazard_a/b, data_a_mgr/b_mgr      operand forwarding overrides
//   wb_en, wb_rd, wb_data             writeback port
//   instr_de, pc_de                   DE contents (to the hazard unit)
//   instr_exe, pc_exe, rs1_val_exe,
//   rs2_val_exe, imm_exe, valid_exe   EXE contents
//   stall_if                          hold fetch (stall & ~flush)
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] BUBBLE_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_if,
  input  logic [XLEN-1:0] pc_if,
  input  logic            valid_if,
  input  logic            stall,
  input  logic            flush,
  input  logic            hazard_a,
  input  logic            hazard_b,
  input  logic [XLEN-1:0] data_a_mgr,
  input  logic [XLEN-1:0] data_b_mgr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [31:0]     instr_de,
  output logic [XLEN-1:0] pc_de,
  output logic [31:0]     instr_exe,
  output logic [XLEN-1:0] pc_exe,
  output logic [XLEN-1:0] rs1_val_exe,
  output logic [XLEN-1:0] rs2_val_exe,
  output logic [XLEN-1:0] imm_exe,
  output logic            valid_exe,
  output logic            stall_if
);
  import rv32_pkg::imm_fmt_t;
  import rv32_pkg::imm_fmt;
  import rv32_pkg::IMM_I;
  import rv32_pkg::IMM_S;
  import rv32_pkg::IMM_B;
  import rv32_pkg::IMM_U;
  import rv32_pkg::IMM_J;

  function automatic logic [31:0] immgen(input logic [31:0] i);
    imm_fmt_t fmt;
    fmt = imm_fmt(i[6:0]);
    case (fmt)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  logic            valid_de;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;

  // A flush outranks a stall, so fetch is never held on a redirect.
  assign stall_if = stall & ~flush;

  // rs1/rs2 fields are read for every format; the hazard unit decides whether they matter.
  regfile_2r1w u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (instr_de[19:15]),
    .rs2_addr (instr_de[24:20]),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // IF/DE: flush > stall > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_de <= NOP_INSTR;
      pc_de    <= BUBBLE_PC;
      valid_de <= 1'b0;
    end else if (flush) begin
      instr_de <= NOP_INSTR;
      pc_de    <= BUBBLE_PC;
      valid_de <= 1'b0;
    end else if (!stall) begin
      instr_de <= valid_if ? instr_if : NOP_INSTR;
      pc_de    <= valid_if ? pc_if    : BUBBLE_PC;
      valid_de <= valid_if;
    end
  end

  // DE/EXE: a stall leaves the instruction in DE and sends a bubble forward,
  // so K stall cycles yield exactly K bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_exe   <= NOP_INSTR;
      pc_exe      <= BUBBLE_PC;
      rs1_val_exe <= '0;
      rs2_val_exe <= '0;
      imm_exe     <= '0;
      valid_exe   <= 1'b0;
    end else if (flush || stall) begin
      instr_exe   <= NOP_INSTR;
      pc_exe      <= BUBBLE_PC;
      rs1_val_exe <= '0;
      rs2_val_exe <= '0;
      imm_exe     <= '0;
      valid_exe   <= 1'b0;
    end else begin
      instr_exe   <= instr_de;
      pc_exe      <= pc_de;
      rs1_val_exe <= hazard_a ? data_a_mgr : rf_rs1;
      rs2_val_exe <= hazard_b ? data_b_mgr : rf_rs2;
      imm_exe     <= immgen(instr_de);
      valid_exe   <= valid_de;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_if, pc_if, data_a_mgr, data_b_mgr, wb_data;
  logic        valid_if, stall, flush, hazard_a, hazard_b, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] instr_de, pc_de, instr_exe, pc_exe, rs1_val_exe, rs2_val_exe, imm_exe;
  logic        valid_exe, stall_if;

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_if(instr_if), .pc_if(pc_if), .valid_if(valid_if),
    .stall(stall), .flush(flush), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .data_a_mgr(data_a_mgr), .data_b_mgr(data_b_mgr), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .instr_de(instr_de), .pc_de(pc_de), .instr_exe(instr_exe),
    .pc_exe(pc_exe), .rs1_val_exe(rs1_val_exe), .rs2_val_exe(rs2_val_exe),
    .imm_exe(imm_exe), .valid_exe(valid_exe), .stall_if(stall_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle 1 time unit so sampling is away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_idle();
    instr_if = 32'hFFFF_FFFF;  // garbage that must not enter DE
    pc_if    = 32'hDEAD_BEE0;
    valid_if = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    data_a_mgr = 32'h0;
    data_b_mgr = 32'h0;
    wb_en    = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'h0;
  endtask

  task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
    instr_if = ins;
    pc_if    = pc;
    valid_if = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    checks++; if (instr_de !== NOP) begin fails++; $display("FAIL reset_instr_de: got %h want %h", instr_de, NOP); end
    checks++; if (instr_exe !== NOP) begin fails++; $display("FAIL reset_instr_exe: got %h want %h", instr_exe, NOP); end
    checks++; if (pc_de !== 32'h0 || pc_exe !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h/%h want 0/0", pc_de, pc_exe); end
    checks++; if (rs1_val_exe !== 32'h0 || rs2_val_exe !== 32'h0 || imm_exe !== 32'h0) begin fails++; $display("FAIL reset_operands: got %h/%h/%h want 0", rs1_val_exe, rs2_val_exe, imm_exe); end
    checks++; if (valid_exe !== 1'b0) begin fails++; $display("FAIL reset_valid_exe: got %b want 0", valid_exe); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    feed(32'hFFF0_0093, 32'h4);
    step();
    checks++; if (instr_de !== 32'hFFF0_0093 || pc_de !== 32'h4) begin fails++; $display("FAIL addi_de: got %h@%h want fff00093@4", instr_de, pc_de); end
    checks++; if (instr_exe !== NOP || valid_exe !== 1'b0) begin fails++; $display("FAIL addi_exe_early: got %h v=%b want %h v=0", instr_exe, valid_exe, NOP); end
    drive_idle();
    step();
    checks++; if (instr_exe !== 32'hFFF0_0093 || pc_exe !== 32'h4) begin fails++; $display("FAIL addi_exe: got %h@%h want fff00093@4", instr_exe, pc_exe); end
    checks++; if (imm_exe !== 32'hFFFF_FFFF) begin fails++; $display("FAIL addi_imm: got %h want ffffffff", imm_exe); end
    checks++; if (rs1_val_exe !== 32'h0 || valid_exe !== 1'b1) begin fails++; $display("FAIL addi_rs1_valid: got %h v=%b want 0 v=1", rs1_val_exe, valid_exe); end
    // Invalid fetch on advance must load a bubble, not the garbage on instr_if.
    checks++; if (instr_de !== NOP || pc_de !== 32'h0) begin fails++; $display("FAIL invalid_fetch_de: got %h@%h want %h@0", instr_de, pc_de, NOP); end
  endtask

  task automatic test_imm();
    logic [31:0] vec_ins [6];
    logic [31:0] vec_imm [6];
    vec_ins[0] = 32'hFE00_0EE3; vec_imm[0] = 32'hFFFF_FFFC;  // beq x0,x0,-4
    vec_ins[1] = 32'h0020_A423; vec_imm[1] = 32'h0000_0008;  // sw x2,8(x1)
    vec_ins[2] = 32'h1234_50B7; vec_imm[2] = 32'h1234_5000;  // lui x1,0x12345
    vec_ins[3] = 32'h0080_00EF; vec_imm[3] = 32'h0000_0008;  // jal x1,+8
    vec_ins[4] = 32'h0020_81B3; vec_imm[4] = 32'h0000_0000;  // add x3,x1,x2
    vec_ins[5] = 32'h8000_2083; vec_imm[5] = 32'hFFFF_F800;  // lw x1,-2048(x0)
    for (int k = 0; k < 6; k++) begin
      feed(vec_ins[k], 32'h100 + 32'(k * 4));
      step();
      drive_idle();
      step();
      checks++; if (imm_exe !== vec_imm[k]) begin fails++; $display("FAIL imm_%0d (%h): got %h want %h", k, vec_ins[k], imm_exe, vec_imm[k]); end
    end
  endtask

  task automatic test_bypass();
    feed(32'h0002_8313, 32'h200);  // addi x6,x5,0
    step();
    drive_idle();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5_A5A5;
    step();
    checks++; if (rs1_val_exe !== 32'hA5A5_A5A5) begin fails++; $display("FAIL bypass_x5: got %h want a5a5a5a5", rs1_val_exe); end
    drive_idle();
    feed(32'h0000_0313, 32'h204);  // addi x6,x0,0
    step();
    drive_idle();
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
    step();
    checks++; if (rs1_val_exe !== 32'h0) begin fails++; $display("FAIL bypass_x0: got %h want 0", rs1_val_exe); end
    drive_idle();
    feed(32'h0002_8313, 32'h208);  // x5 must now hold the written value
    step();
    drive_idle();
    step();
    checks++; if (rs1_val_exe !== 32'hA5A5_A5A5) begin fails++; $display("FAIL rf_x5_stored: got %h want a5a5a5a5", rs1_val_exe); end
  endtask

  task automatic test_forward();
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h11;
    step();
    drive_idle();
    feed(32'h0053_8433, 32'h300);  // add x8,x7,x5
    step();
    drive_idle();
    hazard_a = 1'b1; data_a_mgr = 32'h1234_5678; data_b_mgr = 32'hFFFF_FFFF;
    step();
    checks++; if (rs1_val_exe !== 32'h1234_5678) begin fails++; $display("FAIL fwd_a: got %h want 12345678", rs1_val_exe); end
    checks++; if (rs2_val_exe !== 32'hA5A5_A5A5) begin fails++; $display("FAIL fwd_b_off: got %h want a5a5a5a5", rs2_val_exe); end
    drive_idle();
    feed(32'h0053_8433, 32'h304);
    step();
    drive_idle();
    step();
    checks++; if (rs1_val_exe !== 32'h11) begin fails++; $display("FAIL rf_x7: got %h want 11", rs1_val_exe); end
    // Forwarding wins over a same-cycle writeback bypass.
    feed(32'h0053_8433, 32'h308);
    step();
    drive_idle();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555_0000;
    hazard_b = 1'b1; data_b_mgr = 32'h0BAD_F00D;
    step();
    checks++; if (rs2_val_exe !== 32'h0BAD_F00D) begin fails++; $display("FAIL fwd_over_bypass: got %h want 0badf00d", rs2_val_exe); end
    drive_idle();
  endtask

  task automatic test_stall();
    feed(32'hFFF0_0093, 32'h400);
    step();
    feed(32'h0010_0113, 32'h404);  // addi x2,x0,1
    stall = 1'b1;
    #1;
    checks++; if (stall_if !== 1'b1) begin fails++; $display("FAIL stall_if_high: got %b want 1", stall_if); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (instr_de !== 32'hFFF0_0093 || pc_de !== 32'h400) begin fails++; $display("FAIL stall_hold_%0d: got %h@%h want fff00093@400", c, instr_de, pc_de); end
      checks++; if (instr_exe !== NOP || pc_exe !== 32'h0 || valid_exe !== 1'b0) begin fails++; $display("FAIL stall_bubble_%0d: got %h@%h v=%b want %h@0 v=0", c, instr_exe, pc_exe, valid_exe, NOP); end
    end
    stall = 1'b0;
    step();
    checks++; if (instr_exe !== 32'hFFF0_0093 || pc_exe !== 32'h400 || valid_exe !== 1'b1) begin fails++; $display("FAIL stall_release: got %h@%h v=%b want fff00093@400 v=1", instr_exe, pc_exe, valid_exe); end
    drive_idle();
    step();
    checks++; if (instr_exe !== 32'h0010_0113 || pc_exe !== 32'h404 || imm_exe !== 32'h1) begin fails++; $display("FAIL stall_next: got %h@%h imm=%h want 00100113@404 imm=1", instr_exe, pc_exe, imm_exe); end
  endtask

  task automatic test_flush();
    feed(32'hFFF0_0093, 32'h500);
    step();
    feed(32'h0010_0113, 32'h504);
    step();
    stall = 1'b1; flush = 1'b1;
    #1;
    checks++; if (stall_if !== 1'b0) begin fails++; $display("FAIL flush_stall_if: got %b want 0", stall_if); end
    step();
    checks++; if (instr_de !== NOP || pc_de !== 32'h0) begin fails++; $display("FAIL flush_de: got %h@%h want %h@0", instr_de, pc_de, NOP); end
    checks++; if (instr_exe !== NOP || pc_exe !== 32'h0 || valid_exe !== 1'b0) begin fails++; $display("FAIL flush_exe: got %h@%h v=%b want %h@0 v=0", instr_exe, pc_exe, valid_exe, NOP); end
    drive_idle();
    step();
    checks++; if (valid_exe !== 1'b0) begin fails++; $display("FAIL flush_de_invalid: got v=%b want 0", valid_exe); end
  endtask

  task automatic test_reset_mid();
    feed(32'h0002_8313, 32'h600);
    step();
    feed(32'h0010_0113, 32'h604);
    step();
    #2;
    rst = 1'b1;  // between edges: must take effect without a clock
    #1;
    checks++; if (instr_de !== NOP || instr_exe !== NOP) begin fails++; $display("FAIL midreset_instr: got %h/%h want %h", instr_de, instr_exe, NOP); end
    checks++; if (pc_exe !== 32'h0 || valid_exe !== 1'b0 || imm_exe !== 32'h0 || rs1_val_exe !== 32'h0) begin fails++; $display("FAIL midreset_exe: pc=%h v=%b imm=%h rs1=%h want 0", pc_exe, valid_exe, imm_exe, rs1_val_exe); end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    feed(32'h0053_8433, 32'h608);  // add x8,x7,x5: both were written earlier
    step();
    drive_idle();
    step();
    checks++; if (rs1_val_exe !== 32'h0 || rs2_val_exe !== 32'h0) begin fails++; $display("FAIL midreset_rf_cleared: got %h/%h want 0/0", rs1_val_exe, rs2_val_exe); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_imm();
    test_bypass();
    test_forward();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
